mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (loads/stores driven by the decoder's mem_rd/mem_wr controls).
- Sequences each access through a fixed-latency memory: grant, address hold for WAIT_CYCLES, then a one-cycle ack with registered read data.
- Produces per-stage stall signals consumed by the pipeline hazard/stall logic.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 2, memory read latency in cycles with mem_en held; must be >= 1, elaboration error if 0
- STARVE_MAX, 4, consecutive MEM grants allowed while if_req is pending; used only with the optional feature

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request (level)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse to IF
- dm_rd  in  1  load request (level)
- dm_wr  in  1  store request (level)
- dm_addr  in  ADDR_W  load/store address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid when dm_ack=1
- dm_ack  out  1  one-cycle completion pulse to MEM
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid after WAIT_CYCLES cycles of mem_en
- stall_if  out  1  if_req & ~if_ack
- stall_mem  out  1  (dm_rd | dm_wr) & ~dm_ack

Behaviour:
- Reset values: state IDLE; mem_en, mem_we, if_ack, dm_ack = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; wait counter 0; starvation counter 0.
- FSM states: IDLE, SERVE, ACK.
- IDLE:
  - If dm_rd | dm_wr, grant MEM: latch dm_addr, dm_wdata, write flag (dm_wr) → SERVE.
  - Else if if_req, grant IF: latch if_addr → SERVE.
  - Else stay in IDLE.
- SERVE:
  - mem_en=1; mem_we = latched write flag; mem_addr/mem_wdata driven from the latches, stable for the whole state.
  - Stays exactly WAIT_CYCLES cycles.
  - On the last cycle, mem_rdata is captured into if_rdata or dm_rdata (reads only) → ACK.
- ACK:
  - Exactly one cycle; ack to the granted port = 1; mem_en=0 → IDLE.
  - No arbitration in ACK.
- Access latency: WAIT_CYCLES+2 cycles from a request seen in IDLE to its ack. Throughput: one access per WAIT_CYCLES+2 cycles.
- Handshake:
  - A request may stay high across acks; each ack consumes one request.
  - The pipeline advances on ack, so req high in the following cycle is a new request.
  - Inputs are sampled only in IDLE; address/data changes during SERVE/ACK are ignored.
- Priority: MEM over IF (older instruction first), strict unless the optional feature is compiled in.
- Writes: dm_rdata holds its previous value and dm_ack still pulses.
- dm_rd and dm_wr both high: treated as a write.
- Request withdrawn during SERVE (e.g. flush): the access completes and the ack pulses anyway; the requester ignores it.
- Reset mid-access: immediate return to IDLE, mem_en/mem_we drop next edge, no ack issued. A store in progress is abandoned.
- Rdata registers update only on a completed read for their own port.

Optional Feature:
- Macro: MEM_PORT_ARBITER_FAIRNESS_EN.
- Defined: a starvation counter (width clog2(STARVE_MAX+1)) increments on each MEM grant made while if_req=1 and clears on every IF grant. When the count equals STARVE_MAX and if_req=1, IDLE grants IF even if MEM is requesting.
- Undefined: strict MEM priority; counter logic absent.

Decomposition:
- Package rv_mem_pkg: state enum (IDLE/SERVE/ACK), grant-source enum (GNT_IF/GNT_DM), default ADDR_W/DATA_W constants.
- One sub-module, mem_port_grant: combinational priority selection plus the optional starvation counter. FSM, latches and wait counter stay in the top.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, mem_rdata=0x00A00093 → mem_en high cycles 1-2, if_ack at cycle 3, if_rdata=0x00A00093, stall_if high cycles 0-2.
- if_req and dm_rd both rising same cycle, dm_addr=0x200 → MEM served first (dm_ack cycle 3), IF served next (if_ack cycle 7).
- dm_wr=1, dm_addr=0x204, dm_wdata=0xDEADBEEF → mem_we=1 with mem_addr=0x204 and mem_wdata=0xDEADBEEF for 2 cycles, dm_ack pulses, dm_rdata unchanged.
- Reset asserted in the second SERVE cycle of a load → next cycle mem_en=0, no dm_ack; the following request starts cleanly from IDLE.
- With fairness compiled in and STARVE_MAX=4: dm_rd and if_req held high → grant sequence DM, DM, DM, DM, IF, DM, ...; without the macro, IF is never granted while dm_rd stays high.
- if_req dropped during SERVE → if_ack still pulses once; FSM back to IDLE; no second access issued.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
// Pulled in by mem_port_arbiter and mem_port_grant.
package rv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      ACK   = 2'd2
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_t;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_port_grant.sv
// Priority selection between fetch (IF) and load/store (MEM) requesters.
// MEM wins unless MEM_PORT_ARBITER_FAIRNESS_EN adds a starvation override for IF.
module mem_port_grant
   import rv_mem_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic arb_en,
   input  logic if_req,
   input  logic dm_req,
   output logic gnt_valid,
   output gnt_t gnt_src
);

   assign gnt_valid = if_req | dm_req;

`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

   logic [CW-1:0] starve_q;
   logic          if_forced;

   // At CMAX a pending fetch always wins, so the counter cannot pass CMAX.
   assign if_forced = if_req && (starve_q == CMAX);

   always_comb begin
      gnt_src = GNT_IF;
      if (dm_req && !if_forced) begin
         gnt_src = GNT_DM;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q <= '0;
      end else if (arb_en && gnt_valid) begin
         if (gnt_src == GNT_IF) begin
            starve_q <= '0;
         end else if (if_req) begin
            starve_q <= starve_q + CW'(1);
         end
      end
   end
`else
   localparam int unused_starve_max = STARVE_MAX;
   logic unused_fair;

   assign unused_fair = clk ^ reset ^ arb_en;

   always_comb begin
      gnt_src = GNT_IF;
      if (dm_req) begin
         gnt_src = GNT_DM;
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for IF and MEM stages: grant, WAIT_CYCLES hold, one-cycle ack.
// Optional IF starvation guard is compiled in with MEM_PORT_ARBITER_FAIRNESS_EN.
module mem_port_arbiter
   import rv_mem_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int WAIT_CYCLES = 2,
   parameter int STARVE_MAX  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_rd,
   input  logic              dm_wr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   generate
      if (WAIT_CYCLES < 1) begin : g_bad_wait
         $error("mem_port_arbiter: WAIT_CYCLES must be >= 1");
      end
   endgenerate

   localparam int WW = $clog2(WAIT_CYCLES + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);

   state_t            state_q;
   state_t            state_d;
   gnt_t              gnt_q;
   gnt_t              gnt_src;
   logic              gnt_valid;
   logic              dm_req;
   logic              arb_en;
   logic              serve_last;
   logic              wr_q;
   logic [WW-1:0]     wait_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;

   assign dm_req     = dm_rd | dm_wr;
   assign arb_en     = (state_q == IDLE);
   assign serve_last = (state_q == SERVE) && (wait_q == WAIT_LAST);

   mem_port_grant #(
      .STARVE_MAX (STARVE_MAX)
   ) u_grant (
      .clk       (clk),
      .reset     (reset),
      .arb_en    (arb_en),
      .if_req    (if_req),
      .dm_req    (dm_req),
      .gnt_valid (gnt_valid),
      .gnt_src   (gnt_src)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt_valid) state_d = SERVE;
         SERVE:   if (serve_last) state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request inputs are only looked at in IDLE; everything after comes from the latches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt_q      <= GNT_IF;
         wr_q       <= 1'b0;
         wait_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               wait_q <= '0;
               if (gnt_valid) begin
                  gnt_q <= gnt_src;
                  if (gnt_src == GNT_DM) begin
                     addr_q  <= dm_addr;
                     wdata_q <= dm_wdata;
                     wr_q    <= dm_wr;
                  end else begin
                     addr_q  <= if_addr;
                     wr_q    <= 1'b0;
                  end
               end
            end
            SERVE: begin
               wait_q <= wait_q + WW'(1);
               if (serve_last && !wr_q) begin
                  if (gnt_q == GNT_DM) begin
                     dm_rdata_q <= mem_rdata;
                  end else begin
                     if_rdata_q <= mem_rdata;
                  end
               end
            end
            default: begin
               wait_q <= '0;
            end
         endcase
      end
   end

   assign mem_en    = (state_q == SERVE);
   assign mem_we    = (state_q == SERVE) && wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign if_ack    = (state_q == ACK) && (gnt_q == GNT_IF);
   assign dm_ack    = (state_q == ACK) && (gnt_q == GNT_DM);
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with WAIT_CYCLES=2 and STARVE_MAX=4.
// Expected grant order follows MEM_PORT_ARBITER_FAIRNESS_EN when defined.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_rd;
   logic        dm_wr;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_mem;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .WAIT_CYCLES (2),
      .STARVE_MAX  (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .dm_rd     (dm_rd),
      .dm_wr     (dm_wr),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_ack    (dm_ack),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_if  (stall_if),
      .stall_mem (stall_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Step into the next cycle: just past the rising edge, where inputs change.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [5:0] exp_dm_seq;

   initial begin
`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
      exp_dm_seq = 6'b101111;
`else
      exp_dm_seq = 6'b111111;
`endif
      reset     = 1'b1;
      if_req    = 1'b0;
      if_addr   = '0;
      dm_rd     = 1'b0;
      dm_wr     = 1'b0;
      dm_addr   = '0;
      dm_wdata  = '0;
      mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_mem_en", {31'd0, mem_en}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_dm_rdata", dm_rdata, 32'd0);

      // Single fetch: mem_en cycles 1-2, ack cycle 3.
      cyc();
      reset = 1'b0; if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h00A00093;
      @(negedge clk);
      check("f_c0_en", {31'd0, mem_en}, 32'd0);
      check("f_c0_stall", {31'd0, stall_if}, 32'd1);
      cyc(); @(negedge clk);
      check("f_c1_en", {31'd0, mem_en}, 32'd1);
      check("f_c1_we", {31'd0, mem_we}, 32'd0);
      check("f_c1_addr", mem_addr, 32'h100);
      check("f_c1_stall", {31'd0, stall_if}, 32'd1);
      cyc(); @(negedge clk);
      check("f_c2_en", {31'd0, mem_en}, 32'd1);
      check("f_c2_stall", {31'd0, stall_if}, 32'd1);
      cyc(); @(negedge clk);
      check("f_c3_ack", {31'd0, if_ack}, 32'd1);
      check("f_c3_dmack", {31'd0, dm_ack}, 32'd0);
      check("f_c3_rdata", if_rdata, 32'h00A00093);
      check("f_c3_stall", {31'd0, stall_if}, 32'd0);
      check("f_c3_en", {31'd0, mem_en}, 32'd0);
      cyc();
      if_req = 1'b0;
      @(negedge clk);
      check("f_c4_ack", {31'd0, if_ack}, 32'd0);
      check("f_c4_en", {31'd0, mem_en}, 32'd0);

      // Simultaneous requests: MEM first (ack cycle 3), IF next (ack cycle 7).
      cyc();
      if_req = 1'b1; if_addr = 32'h104; dm_rd = 1'b1; dm_addr = 32'h200; mem_rdata = 32'h11112222;
      @(negedge clk);
      check("p_c0_stall_mem", {31'd0, stall_mem}, 32'd1);
      cyc(); @(negedge clk);
      check("p_c1_addr", mem_addr, 32'h200);
      cyc(); @(negedge clk);
      cyc(); @(negedge clk);
      check("p_c3_dmack", {31'd0, dm_ack}, 32'd1);
      check("p_c3_ifack", {31'd0, if_ack}, 32'd0);
      check("p_c3_dmrdata", dm_rdata, 32'h11112222);
      check("p_c3_stall_mem", {31'd0, stall_mem}, 32'd0);
      check("p_c3_stall_if", {31'd0, stall_if}, 32'd1);
      cyc();
      dm_rd = 1'b0; mem_rdata = 32'h33334444;
      @(negedge clk);
      check("p_c4_en", {31'd0, mem_en}, 32'd0);
      check("p_c4_dmack", {31'd0, dm_ack}, 32'd0);
      cyc(); @(negedge clk);
      check("p_c5_en", {31'd0, mem_en}, 32'd1);
      check("p_c5_addr", mem_addr, 32'h104);
      cyc(); @(negedge clk);
      cyc(); @(negedge clk);
      check("p_c7_ifack", {31'd0, if_ack}, 32'd1);
      check("p_c7_ifrdata", if_rdata, 32'h33334444);
      check("p_c7_dmrdata", dm_rdata, 32'h11112222);
      cyc();
      if_req = 1'b0;

      // Store: write flags and data held for both SERVE cycles, dm_rdata untouched.
      cyc();
      dm_wr = 1'b1; dm_addr = 32'h204; dm_wdata = 32'hDEADBEEF; mem_rdata = 32'h55556666;
      @(negedge clk);
      cyc();
      dm_addr = 32'h999; dm_wdata = 32'h0;
      @(negedge clk);
      check("w_c1_we", {31'd0, mem_we}, 32'd1);
      check("w_c1_addr", mem_addr, 32'h204);
      check("w_c1_wdata", mem_wdata, 32'hDEADBEEF);
      cyc(); @(negedge clk);
      check("w_c2_we", {31'd0, mem_we}, 32'd1);
      check("w_c2_addr", mem_addr, 32'h204);
      check("w_c2_wdata", mem_wdata, 32'hDEADBEEF);
      cyc(); @(negedge clk);
      check("w_c3_dmack", {31'd0, dm_ack}, 32'd1);
      check("w_c3_we", {31'd0, mem_we}, 32'd0);
      check("w_c3_dmrdata", dm_rdata, 32'h11112222);
      cyc();
      dm_wr = 1'b0; dm_addr = 32'h0;

      // Reset in the second SERVE cycle of a load, then a clean restart.
      cyc();
      dm_rd = 1'b1; dm_addr = 32'h300; mem_rdata = 32'h77778888;
      @(negedge clk);
      cyc(); @(negedge clk);
      check("r_c1_en", {31'd0, mem_en}, 32'd1);
      cyc();
      reset = 1'b1; dm_rd = 1'b0;
      @(negedge clk);
      check("r_c2_en", {31'd0, mem_en}, 32'd1);
      cyc(); @(negedge clk);
      check("r_c3_en", {31'd0, mem_en}, 32'd0);
      check("r_c3_we", {31'd0, mem_we}, 32'd0);
      check("r_c3_dmack", {31'd0, dm_ack}, 32'd0);
      check("r_c3_dmrdata", dm_rdata, 32'd0);
      cyc();
      reset = 1'b0; dm_rd = 1'b1; dm_addr = 32'h304; mem_rdata = 32'h9999AAAA;
      @(negedge clk);
      check("r_c4_dmack", {31'd0, dm_ack}, 32'd0);
      check("r_c4_en", {31'd0, mem_en}, 32'd0);
      cyc(); @(negedge clk);
      check("r_c5_en", {31'd0, mem_en}, 32'd1);
      check("r_c5_addr", mem_addr, 32'h304);
      cyc(); @(negedge clk);
      cyc(); @(negedge clk);
      check("r_c7_dmack", {31'd0, dm_ack}, 32'd1);
      check("r_c7_dmrdata", dm_rdata, 32'h9999AAAA);
      cyc();
      dm_rd = 1'b0;

      // Fetch withdrawn during SERVE: ack still pulses once, no follow-up access.
      cyc();
      if_req = 1'b1; if_addr = 32'h108; mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      cyc();
      if_req = 1'b0;
      @(negedge clk);
      check("x_c1_en", {31'd0, mem_en}, 32'd1);
      check("x_c1_stall", {31'd0, stall_if}, 32'd0);
      cyc(); @(negedge clk);
      cyc(); @(negedge clk);
      check("x_c3_ifack", {31'd0, if_ack}, 32'd1);
      check("x_c3_rdata", if_rdata, 32'h0BADF00D);
      for (int k = 4; k <= 6; k++) begin
         cyc(); @(negedge clk);
         check($sformatf("x_c%0d_en", k), {31'd0, mem_en}, 32'd0);
         check($sformatf("x_c%0d_ifack", k), {31'd0, if_ack}, 32'd0);
      end

      // Both requesters held high: grant order observed at each ack.
      cyc();
      dm_rd = 1'b1; dm_addr = 32'h400; if_req = 1'b1; if_addr = 32'h10C; mem_rdata = 32'h12345678;
      for (int a = 0; a < 6; a++) begin
         repeat ((a == 0) ? 3 : 4) cyc();
         @(negedge clk);
         check($sformatf("s_dmack_%0d", a), {31'd0, dm_ack}, {31'd0, exp_dm_seq[a]});
         check($sformatf("s_ifack_%0d", a), {31'd0, if_ack}, {31'd0, ~exp_dm_seq[a]});
      end
      cyc();
      dm_rd = 1'b0; if_req = 1'b0;
      repeat (2) cyc();
      @(negedge clk);
      check("end_en", {31'd0, mem_en}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
